// File: rtl/ss_arb_pkg.sv
// Shared types and helpers for the sort-engine start arbiter.
// Holds the FSM state encoding and the round-robin search.
package ss_arb_pkg;

   localparam int MAX_CH = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_RUN
   } state_t;

   // First set bit of req searching upward from last+1, wrapping at n.
   function automatic int rr_next(
      input logic [MAX_CH-1:0] req,
      input int                last,
      input int                n
   );
      int idx;
      rr_next = last;
      for (int k = MAX_CH; k >= 1; k--) begin
         if (k <= n) begin
            idx = last + k;
            if (idx >= n) idx = idx - n;
            if (req[idx[4:0]]) rr_next = idx;
         end
      end
   endfunction

endpackage

// File: rtl/ss_edge_vec.sv
// Per-bit edge detector with selectable polarity.
// The history resets to the active level, so levels held through reset are ignored.
module ss_edge_vec
   import ss_arb_pkg::*;
#(
   parameter int   WIDTH    = 1,
   parameter logic POS_EDGE = 1'b1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] pulse
);

   logic [WIDTH-1:0] prev;

   // Remember last sample of every bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev <= {WIDTH{POS_EDGE}};
      else        prev <= din;
   end

   assign pulse = POS_EDGE ? (din & ~prev) : (~din & prev);

endmodule

// File: rtl/ss_start_arbiter.sv
// Round-robin start/done arbiter in front of the shared sort engine.
// Queues per-channel start edges and runs one job at a time with optional timeout.
module ss_start_arbiter
   import ss_arb_pkg::*;
#(
   parameter  int   N_CH      = 4,
   parameter  logic POS_EDGE  = 1'b1,
   parameter  int   TIMEOUT_W = 16,
   localparam int   CH_W      = $clog2(N_CH)
)(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [N_CH-1:0]      i_start,
   input  logic                 i_done,
   input  logic [TIMEOUT_W-1:0] i_timeout,
   output logic                 o_launch,
   output logic [CH_W-1:0]      o_ch_id,
   output logic                 o_busy,
   output logic [N_CH-1:0]      o_pending,
   output logic [N_CH-1:0]      o_done_ch,
   output logic                 o_timeout
);

   state_t               state, state_nxt;
   logic [N_CH-1:0]      st_pulse;
   logic                 dn_pulse;
   logic [CH_W-1:0]      last, last_nxt;
   logic [CH_W-1:0]      ch_nxt, pick;
   logic [N_CH-1:0]      pend_nxt, done_nxt;
   logic [TIMEOUT_W-1:0] tmo, tmo_nxt;
   logic [TIMEOUT_W-1:0] cnt, cnt_nxt;
   logic                 launch_nxt, busy_nxt, to_nxt;

   ss_edge_vec #(.WIDTH(N_CH), .POS_EDGE(POS_EDGE)) u_start_edge (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .din   (i_start),
      .pulse (st_pulse)
   );

   ss_edge_vec #(.WIDTH(1), .POS_EDGE(POS_EDGE)) u_done_edge (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .din   (i_done),
      .pulse (dn_pulse)
   );

   assign pick = CH_W'(rr_next(MAX_CH'(o_pending), int'(last), N_CH));

   // Next-state, pending queue, counter and output pulse decisions.
   always_comb begin
      state_nxt  = state;
      last_nxt   = last;
      ch_nxt     = o_ch_id;
      pend_nxt   = o_pending | st_pulse;
      tmo_nxt    = tmo;
      cnt_nxt    = cnt;
      launch_nxt = 1'b0;
      busy_nxt   = o_busy;
      done_nxt   = '0;
      to_nxt     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (|o_pending) begin
               ch_nxt     = pick;
               pend_nxt   = (o_pending & ~(N_CH'(1) << pick)) | st_pulse;
               tmo_nxt    = i_timeout;
               launch_nxt = 1'b1;
               busy_nxt   = 1'b1;
               state_nxt  = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            cnt_nxt   = '0;
            state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (cnt != '1) cnt_nxt = cnt + 1'b1;
            if (dn_pulse) begin
               done_nxt  = N_CH'(1) << o_ch_id;
               busy_nxt  = 1'b0;
               last_nxt  = o_ch_id;
               state_nxt = ST_IDLE;
            end else if (tmo != '0 && cnt == tmo - 1'b1) begin
               to_nxt    = 1'b1;
               busy_nxt  = 1'b0;
               last_nxt  = o_ch_id;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_IDLE;
         last      <= CH_W'(N_CH - 1);
         o_ch_id   <= '0;
         o_pending <= '0;
         tmo       <= '0;
         cnt       <= '0;
         o_launch  <= 1'b0;
         o_busy    <= 1'b0;
         o_done_ch <= '0;
         o_timeout <= 1'b0;
      end else begin
         state     <= state_nxt;
         last      <= last_nxt;
         o_ch_id   <= ch_nxt;
         o_pending <= pend_nxt;
         tmo       <= tmo_nxt;
         cnt       <= cnt_nxt;
         o_launch  <= launch_nxt;
         o_busy    <= busy_nxt;
         o_done_ch <= done_nxt;
         o_timeout <= to_nxt;
      end
   end

endmodule

// File: doc/ss_start_arbiter.md
# ss_start_arbiter

Multi-channel start/done controller for the sort engine. It edge-detects start requests from `N_CH` independent requesters and queues them as pending bits. It grants the single shared sort engine to one channel at a time in round-robin order, then holds busy until the engine's done edge or a programmable timeout. It replaces the single-channel start/done flag logic in front of the engine.

## Interface
- `N_CH`, 4: number of requesting channels (≥2).
- `POS_EDGE`, 1'b1: 1 = rising-edge detection on `i_start`/`i_done`; 0 = falling-edge detection.
- `TIMEOUT_W`, 16: width of the timeout counter and `i_timeout`.
- Derived constant `CH_W` = `$clog2(N_CH)`.

Ports:
- `i_clk`  in  1  clock, all logic on rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_start`  in  N_CH  per-channel start request, level; an active edge is one request.
- `i_done`  in  1  engine done, level; an active edge ends the current job.
- `i_timeout`  in  TIMEOUT_W  max RUN cycles per job; 0 = timeout disabled.
- `o_launch`  out  1  one-cycle pulse, engine start.
- `o_ch_id`  out  CH_W  channel owning the engine; valid while `o_busy`.
- `o_busy`  out  1  engine granted (LAUNCH or RUN).
- `o_pending`  out  N_CH  queued, not yet granted requests.
- `o_done_ch`  out  N_CH  one-hot, one-cycle pulse on normal completion.
- `o_timeout`  out  1  one-cycle pulse on job abort by timeout.

## Operation
- Edge detect: a per-bit previous-value register holds the last sample. Edge = `cur & ~prev` (POS_EDGE=1) or `~cur & prev` (POS_EDGE=0). The previous-value register resets to `POS_EDGE`, so a level already active at reset release is not a request.
- Pending: bit c sets on a start edge on c. It clears when c is granted. A set and a clear in the same cycle leave the bit set. An edge on an already-pending channel is absorbed.
- FSM states are IDLE, LAUNCH and RUN.
  - IDLE: if `o_pending` ≠ 0, grant the first set bit searching from `last_grant+1` mod N_CH. Register `o_ch_id`, clear that pending bit, latch `i_timeout`, and go to LAUNCH.
  - LAUNCH (1 cycle): `o_launch`=1, clear the timeout counter, then go to RUN.
  - RUN: the counter increments each cycle.
    - On a done edge: pulse `o_done_ch[o_ch_id]`, update `last_grant`, go to IDLE.
    - If the latched timeout ≠ 0 and the counter reaches the latched timeout − 1 with no done edge: pulse `o_timeout`, update `last_grant`, go to IDLE.
- Done edges in IDLE or LAUNCH are discarded.
- A start edge on the running channel re-queues it as pending.
- Reset values: state=IDLE, `last_grant`=N_CH−1 (channel 0 first), and every output 0 (`o_ch_id`=0).
- Reset mid-job: everything returns to reset values immediately, and pending requests are lost.

## Timing
- All outputs are registered.
- If a start edge is sampled at clock edge t, `o_pending[c]` goes high after t, and `o_launch`/`o_busy` go high after t+1 when the engine is idle.
- `o_busy` stays high from the LAUNCH cycle through the last RUN cycle and falls in the same cycle the `o_done_ch`/`o_timeout` pulse is high.
- Done edge sampled at edge d gives a `o_done_ch` pulse in cycle d..d+1. The earliest next `o_launch` is after d+1, giving 1 idle cycle minimum between jobs.
- Done edge and timeout in the same cycle: done wins, with no `o_timeout`.
- With `i_timeout`=T, the `o_timeout` pulse occurs at the end of the T-th RUN cycle.
- The counter saturates and never wraps when the timeout is disabled.

## Structure
- Package `ss_arb_pkg` holds the FSM state enum (`ST_IDLE`, `ST_LAUNCH`, `ST_RUN`) and the round-robin next-index function.
- Sub-module `ss_edge_vec`: a WIDTH-parametrised vector edge detector with POS_EDGE polarity. It is instantiated once for `i_start` (WIDTH=N_CH) and once for `i_done` (WIDTH=1).

## Test plan
- Reset release with `i_start`=4'b0001 already high → no pending. Drop it and raise it again → `o_pending`=0001, then `o_launch` one cycle later with `o_ch_id`=0.
- Same-cycle edges on `i_start`=4'b1011 with an instant done per job → grants in order 0, 1, 3. Each has one `o_done_ch` pulse: 0001, 0010, 1000.
- `i_timeout`=5 and no done → `o_timeout` pulses after the 5th RUN cycle, `o_done_ch` stays 0, and the next pending channel launches.
- Done edge in the same cycle the counter hits the timeout → `o_done_ch` pulses, `o_timeout`=0.
- Start edge on running channel 2 mid-job → `o_pending[2]`=1, and after done channel 2 is relaunched if it is next in rotation.
- `i_rst_n` asserted during RUN with pending=0110 → all outputs 0 immediately. No launch occurs after release until new start edges.
